// File: rtl/riscv_pkg.sv
// Shared types and encodings for the RISC-V pipeline: control bundle,
// ALU operation codes, result-source codes and forwarding selects.
package riscv_pkg;

  typedef struct packed {
    logic       RegWrite;
    logic       MemWrite;
    logic       Jump;
    logic       Branch;
    logic       AluSrc;
    logic [1:0] ResultSrc;
    logic [2:0] ALUControl;
    logic [2:0] Funct3;
  } ctrl_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/execute_stage_alu.sv
// Execute-stage ALU: add/sub/and/or/signed slt, every other code yields zero.
module alu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero
);

  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      ALU_ADD: ALUResult = SrcA + SrcB;
      ALU_SUB: ALUResult = SrcA - SrcB;
      ALU_AND: ALUResult = SrcA & SrcB;
      ALU_OR:  ALUResult = SrcA | SrcB;
      ALU_SLT: ALUResult = {{(XLEN-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      default: ALUResult = '0;
    endcase
  end

  assign Zero = (ALUResult == '0);

endmodule

// File: rtl/execute_stage.sv
// ID/EX register, forwarding muxes, ALU, branch resolution and EX/MEM register.
// Define BRANCH_EXT_EN for full Funct3 branch decode; otherwise only beq.
module execute_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            FlushE,
  input  ctrl_t           CtrlD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [XLEN-1:0] ExtImmD,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic [1:0]      ResultSrcE,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [4:0]      RdM,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM
);

  ctrl_t           ctrl_q, ctrl_d;
  logic [XLEN-1:0] rd1_q, rd1_d, rd2_q, rd2_d, pc_q, pc_d, pc4_q, pc4_d, imm_q, imm_d;
  logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;

  // A flush turns the incoming instruction into an all-zero bubble.
  always_comb begin
    ctrl_d = CtrlD;
    rd1_d  = RD1D;
    rd2_d  = RD2D;
    pc_d   = PCD;
    pc4_d  = PCPlus4D;
    imm_d  = ExtImmD;
    rs1_d  = Rs1D;
    rs2_d  = Rs2D;
    rd_d   = RdD;
    if (FlushE) begin
      ctrl_d = '0;
      rd1_d  = '0;
      rd2_d  = '0;
      pc_d   = '0;
      pc4_d  = '0;
      imm_d  = '0;
      rs1_d  = '0;
      rs2_d  = '0;
      rd_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      pc_q   <= '0;
      pc4_q  <= '0;
      imm_q  <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      pc_q   <= pc_d;
      pc4_q  <= pc4_d;
      imm_q  <= imm_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
      rd_q   <= rd_d;
    end
  end

  logic [XLEN-1:0] src_a, src_b, wdata_e, alu_res;
  logic            alu_zero_unused, taken;

  always_comb begin
    case (ForwardAE)
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = ALUResultM;
      default: src_a = rd1_q;
    endcase
    case (ForwardBE)
      FWD_WB:  wdata_e = ResultW;
      FWD_MEM: wdata_e = ALUResultM;
      default: wdata_e = rd2_q;
    endcase
  end

  assign src_b = ctrl_q.AluSrc ? imm_q : wdata_e;

  alu #(.XLEN(XLEN)) u_alu (
    .SrcA       (src_a),
    .SrcB       (src_b),
    .ALUControl (ctrl_q.ALUControl),
    .ALUResult  (alu_res),
    .Zero       (alu_zero_unused)
  );

  // Branch condition compares the forwarded operands directly, independent of the ALU op.
`ifdef BRANCH_EXT_EN
  always_comb begin
    taken = 1'b0;
    case (ctrl_q.Funct3)
      F3_BEQ:  taken = (src_a == src_b);
      F3_BNE:  taken = (src_a != src_b);
      F3_BLT:  taken = ($signed(src_a) <  $signed(src_b));
      F3_BGE:  taken = ($signed(src_a) >= $signed(src_b));
      F3_BLTU: taken = (src_a <  src_b);
      F3_BGEU: taken = (src_a >= src_b);
      default: taken = 1'b0;
    endcase
  end
`else
  logic [2:0] funct3_unused;
  assign funct3_unused = ctrl_q.Funct3;
  assign taken = (src_a == src_b);
`endif

  assign PCSrcE     = ctrl_q.Jump | (ctrl_q.Branch & taken);
  assign PCTargetE  = pc_q + imm_q;
  assign Rs1E       = rs1_q;
  assign Rs2E       = rs2_q;
  assign RdE        = rd_q;
  assign ResultSrcE = ctrl_q.ResultSrc;

  always_ff @(posedge clk) begin
    if (rst) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RdM        <= '0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
    end else begin
      ALUResultM <= alu_res;
      WriteDataM <= wdata_e;
      PCPlus4M   <= pc4_q;
      RdM        <= rd_q;
      RegWriteM  <= ctrl_q.RegWrite;
      MemWriteM  <= ctrl_q.MemWrite;
      ResultSrcM <= ctrl_q.ResultSrc;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Randomized + directed bench for execute_stage against an instruction-level model.
module tb_execute_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, FlushE;
  ctrl_t       CtrlD;
  logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ExtImmD, ResultW;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        PCSrcE, RegWriteM, MemWriteM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  Rs1E, Rs2E, RdE, RdM;
  logic [1:0]  ResultSrcE, ResultSrcM;

  execute_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .FlushE(FlushE), .CtrlD(CtrlD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ExtImmD(ExtImmD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .ResultSrcE(ResultSrcE), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M), .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM)
  );

  always #5 clk = ~clk;

  // Instruction sitting in EX, and the results sitting in MEM.
  typedef struct packed {
    ctrl_t       c;
    logic [31:0] rd1, rd2, pc, pc4, imm;
    logic [4:0]  rs1, rs2, rd;
  } ex_t;
  typedef struct packed {
    logic [31:0] alu, wd, pc4;
    logic [4:0]  rd;
    logic        rw, mw;
    logic [1:0]  rs;
  } mem_t;

  ex_t  ex;
  mem_t m;
  int   n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] rf,
                                       input logic [31:0] w, input logic [31:0] mm);
    if (s == 2'd1) return w;
    if (s == 2'd2) return mm;
    return rf;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Everything the EX instruction produces, given the current forwarding inputs.
  task automatic ex_eval(output logic [31:0] res, output logic [31:0] wd,
                         output logic pcsrc, output logic [31:0] tgt);
    logic [31:0] a, b;
    logic        tk;
    a  = pick(ForwardAE, ex.rd1, ResultW, m.alu);
    wd = pick(ForwardBE, ex.rd2, ResultW, m.alu);
    b  = ex.c.AluSrc ? ex.imm : wd;
    res = alu_ref(ex.c.ALUControl, a, b);
`ifdef BRANCH_EXT_EN
    case (ex.c.Funct3)
      3'd0: tk = (a == b);
      3'd1: tk = (a != b);
      3'd4: tk = (int'(a) < int'(b));
      3'd5: tk = (int'(a) >= int'(b));
      3'd6: tk = (a < b);
      3'd7: tk = (a >= b);
      default: tk = 1'b0;
    endcase
`else
    tk = (a == b);
`endif
    pcsrc = ex.c.Jump | (ex.c.Branch & tk);
    tgt   = ex.pc + ex.imm;
  endtask

  task automatic compare_all();
    logic [31:0] res, wd, tgt;
    logic        pcsrc;
    ex_eval(res, wd, pcsrc, tgt);
    chk("PCSrcE", PCSrcE, pcsrc);
    chk("PCTargetE", PCTargetE, tgt);
    chk("Rs1E", Rs1E, ex.rs1);
    chk("Rs2E", Rs2E, ex.rs2);
    chk("RdE", RdE, ex.rd);
    chk("ResultSrcE", ResultSrcE, ex.c.ResultSrc);
    chk("ALUResultM", ALUResultM, m.alu);
    chk("WriteDataM", WriteDataM, m.wd);
    chk("PCPlus4M", PCPlus4M, m.pc4);
    chk("RdM", RdM, m.rd);
    chk("RegWriteM", RegWriteM, m.rw);
    chk("MemWriteM", MemWriteM, m.mw);
    chk("ResultSrcM", ResultSrcM, m.rs);
  endtask

  // One clock: advance the model with the inputs applied before the edge, then compare.
  task automatic step();
    logic [31:0] res, wd, tgt;
    logic        pcsrc;
    mem_t        nm;
    ex_t         ne;
    ex_eval(res, wd, pcsrc, tgt);
    nm = '{alu: res, wd: wd, pc4: ex.pc4, rd: ex.rd, rw: ex.c.RegWrite,
           mw: ex.c.MemWrite, rs: ex.c.ResultSrc};
    ne = '{c: CtrlD, rd1: RD1D, rd2: RD2D, pc: PCD, pc4: PCPlus4D, imm: ExtImmD,
           rs1: Rs1D, rs2: Rs2D, rd: RdD};
    @(posedge clk);
    if (rst) begin
      ex = '0;
      m  = '0;
    end else begin
      m  = nm;
      ex = FlushE ? '0 : ne;
    end
    #1;
    compare_all();
  endtask

  task automatic drive(input ctrl_t c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd);
    CtrlD = c; RD1D = a; RD2D = b; PCD = pc; PCPlus4D = pc + 32'd4; ExtImmD = imm;
    Rs1D = 5'd1; Rs2D = 5'd2; RdD = rd;
  endtask

  initial begin
    ctrl_t       c;
    logic [13:0] r14;
    ex = '0; m = '0;
    rst = 1'b1; FlushE = 1'b0; ForwardAE = 2'd0; ForwardBE = 2'd0; ResultW = '0;
    drive('0, 32'h11, 32'h22, 32'h100, 32'h8, 5'd9);
    step(); step();
    chk("rst_ALUResultM", ALUResultM, 32'd0);
    chk("rst_PCSrcE", PCSrcE, 1'b0);
    chk("rst_PCTargetE", PCTargetE, 32'd0);
    chk("rst_RegWriteM", RegWriteM, 1'b0);
    rst = 1'b0;

    // add 5+7 reaches MEM two edges later
    c = '0; c.RegWrite = 1'b1; c.ALUControl = ALU_ADD;
    drive(c, 32'd5, 32'd7, 32'h0, 32'h0, 5'd3); step();
    drive('0, 0, 0, 0, 0, 0); step();
    chk("add_ALUResultM", ALUResultM, 32'd12);
    chk("add_RegWriteM", RegWriteM, 1'b1);
    chk("add_RdM", RdM, 5'd3);

    // forwarding from MEM then from WB
    drive(c, 32'h80, 32'h80, 0, 0, 5'd4); step();
    drive(c, 32'h999, 32'd1, 0, 0, 5'd5); step();
    ForwardAE = FWD_MEM;
    drive(c, 32'h555, 32'd1, 0, 0, 5'd6); step();
    chk("fwd_mem", ALUResultM, 32'h101);
    ForwardAE = FWD_WB; ResultW = 32'd3;
    drive('0, 0, 0, 0, 0, 0); step();
    chk("fwd_wb", ALUResultM, 32'd4);
    ForwardAE = FWD_RF; ResultW = '0;

    // beq taken, then not taken
    c = '0; c.Branch = 1'b1; c.ALUControl = ALU_SUB; c.Funct3 = F3_BEQ;
    drive(c, 32'd9, 32'd9, 32'h40, 32'hFFFF_FFF8, 5'd0); step();
    chk("br_taken", PCSrcE, 1'b1);
    chk("br_target", PCTargetE, 32'h38);
    drive(c, 32'd9, 32'd8, 32'h40, 32'hFFFF_FFF8, 5'd0); step();
    chk("br_not_taken", PCSrcE, 1'b0);

    // flushed jump never redirects nor writes
    c = '0; c.Jump = 1'b1; c.MemWrite = 1'b1; c.RegWrite = 1'b1;
    drive(c, 32'd1, 32'd2, 32'h10, 32'h20, 5'd5); FlushE = 1'b1; step();
    chk("flush_PCSrcE", PCSrcE, 1'b0);
    FlushE = 1'b0; drive('0, 0, 0, 0, 0, 0); step();
    chk("flush_MemWriteM", MemWriteM, 1'b0);
    chk("flush_RegWriteM", RegWriteM, 1'b0);
    chk("flush_RdM", RdM, 5'd0);

    // signed slt and add wrap
    c = '0; c.ALUControl = ALU_SLT;
    drive(c, 32'hFFFF_FFFF, 32'd1, 0, 0, 5'd1); step();
    c.ALUControl = ALU_ADD;
    drive(c, 32'hFFFF_FFFF, 32'd1, 0, 0, 5'd1); step();
    chk("slt_neg", ALUResultM, 32'd1);
    drive('0, 0, 0, 0, 0, 0); step();
    chk("add_wrap", ALUResultM, 32'd0);

    c = '0; c.Branch = 1'b1;
`ifdef BRANCH_EXT_EN
    c.Funct3 = F3_BLT;
    drive(c, 32'hFFFF_FFFF, 32'd1, 0, 0, 0); step();
    chk("blt_taken", PCSrcE, 1'b1);
    c.Funct3 = F3_BLTU;
    drive(c, 32'hFFFF_FFFF, 32'd1, 0, 0, 0); step();
    chk("bltu_not_taken", PCSrcE, 1'b0);
`else
    c.Funct3 = F3_BNE;
    drive(c, 32'd42, 32'd42, 0, 0, 0); step();
    chk("beq_only_taken", PCSrcE, 1'b1);
`endif

    // reset mid-stream drops everything in flight
    c = '0; c.RegWrite = 1'b1; c.Jump = 1'b1;
    drive(c, 32'd1, 32'd2, 32'h80, 32'h4, 5'd7); step();
    drive(c, 32'd3, 32'd4, 32'h84, 32'h4, 5'd8); rst = 1'b1; FlushE = 1'b0; step();
    chk("mid_rst_RegWriteM", RegWriteM, 1'b0);
    chk("mid_rst_RdE", RdE, 5'd0);
    chk("mid_rst_PCSrcE", PCSrcE, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      r14 = 14'($urandom);
      c   = r14;
      drive(c, $urandom, 32'd0, $urandom, $urandom, 5'($urandom));
      RD2D = ($urandom_range(0, 2) == 0) ? RD1D : $urandom;
      if ($urandom_range(0, 3) == 0) RD2D = $urandom_range(0, 3);
      Rs1D = 5'($urandom); Rs2D = 5'($urandom);
      ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
      ResultW = ($urandom_range(0, 3) == 0) ? RD1D : $urandom;
      FlushE  = ($urandom_range(0, 7) == 0);
      rst     = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of all data/address ports.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 FlushE  input  1  loads a bubble into the ID/EX register on the next edge.
REQ-005 CtrlD  input  ctrl_t  decoded control: RegWrite, MemWrite, Jump, Branch, AluSrc, ResultSrc[1:0], ALUControl[2:0], Funct3[2:0].
REQ-006 RD1D, RD2D  input  XLEN  register-file read data.
REQ-007 PCD, PCPlus4D, ExtImmD  input  XLEN  decode-stage PC, PC+4, extended immediate.
REQ-008 Rs1D, Rs2D, RdD  input  5  decode-stage register indices.
REQ-009 ForwardAE, ForwardBE  input  2  forwarding selects from the hazard unit.
REQ-010 ResultW  input  XLEN  writeback result for forwarding.
REQ-011 PCSrcE  output  1  redirect fetch to PCTargetE.
REQ-012 PCTargetE  output  XLEN  branch/jump target.
REQ-013 Rs1E, Rs2E, RdE  output  5  execute-stage indices, to the hazard unit.
REQ-014 ResultSrcE  output  2  execute-stage ResultSrc, for load-use detection.
REQ-015 ALUResultM, WriteDataM, PCPlus4M  output  XLEN  EX/MEM register data.
REQ-016 RdM  output  5; RegWriteM, MemWriteM  output  1; ResultSrcM  output  2 -- EX/MEM register fields.

Function
REQ-017 ID/EX register SHALL capture all D inputs on every rising edge; no stall input exists.
REQ-018 EX/MEM register SHALL capture the execute results on every rising edge; D inputs appear at M outputs exactly 2 edges later.
REQ-019 SrcAE mux: 00 -> RD1E, 01 -> ResultW, 10 -> ALUResultM, 11 -> RD1E; the same encoding applies to ForwardBE producing WriteDataE.
REQ-020 SrcBE SHALL be ExtImmE when AluSrcE=1, else WriteDataE; WriteDataM SHALL register WriteDataE (the forwarded value).
REQ-021 ALUControl: 000 add, 001 sub, 010 and, 011 or, 101 signed set-less-than; all other codes SHALL yield 0.
REQ-022 Add, sub and PCTargetE = PCE + ExtImmE SHALL wrap modulo 2^XLEN with no carry output.
REQ-023 PCSrcE SHALL equal JumpE OR (BranchE AND taken); it is purely combinational from the ID/EX register.
REQ-024 FlushE=1 SHALL load the ID/EX register with all zeros (RegWrite, MemWrite, Jump, Branch and Rd all 0), so the next EX cycle produces PCSrcE=0 and a no-write M entry.

Reset
REQ-025 rst=1 SHALL clear every ID/EX and EX/MEM field to 0, so all outputs are 0 after the edge, including PCSrcE, PCTargetE and RegWriteM.
REQ-026 rst SHALL take priority over FlushE; mid-stream reset SHALL discard all in-flight instructions.

Configuration
REQ-027 Macro BRANCH_EXT_EN defined: taken SHALL be decided by Funct3E: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu; codes 010/011 SHALL be not-taken.
REQ-028 Macro BRANCH_EXT_EN undefined: taken SHALL equal (SrcAE == SrcBE) regardless of Funct3E, giving beq only.

Structure
REQ-029 Package riscv_pkg SHALL hold ctrl_t, the ALUControl codes, the ResultSrc codes and the forward-select codes.
REQ-030 The ALU SHALL be a sub-module named alu (inputs SrcA, SrcB, ALUControl; outputs ALUResult, Zero).

Verification
REQ-031 add: RD1D=5, RD2D=7, AluSrc=0, ALUControl=000 -> ALUResultM=12 two edges later, with RegWriteM following CtrlD.
REQ-032 Forwarding: ForwardAE=10 with ALUResultM=0x100 and RD2D=1, add -> next ALUResultM=0x101; ForwardAE=01 with ResultW=3 -> 4.
REQ-033 Branch: PCD=0x40, ExtImmD=0xFFFFFFF8, Branch=1, equal operands -> PCSrcE=1 and PCTargetE=0x38; unequal operands -> PCSrcE=0.
REQ-034 Flush: FlushE=1 alongside a Jump=1 MemWrite=1 instruction -> PCSrcE=0 next cycle, then MemWriteM=0, RegWriteM=0, RdM=0.
REQ-035 slt/wrap: SrcA=0xFFFFFFFF, SrcB=1, slt -> 1; add 0xFFFFFFFF+1 -> 0.
REQ-036 Config: with BRANCH_EXT_EN, blt -1 vs 1 -> taken and bltu -> not taken; without it, Funct3=001 and equal operands -> taken.
